// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter for a codec-mastered DAC: buffers stereo frames from a valid/ready producer
// and shifts them out MSB first on the codec's BCLK/DACLRC with the standard one-bit delay.
module audio_dac_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [DATA_WIDTH-1:0]       s_left,
  input  logic [DATA_WIDTH-1:0]       s_right,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        aud_bclk,
  input  logic                        aud_daclrc,
  output logic                        aud_dacdat,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow,
  input  logic                        clear_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WORD_BITS = CW'(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } frame_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_LEFT,
    ST_RIGHT
  } phase_t;

  logic                  bclk_s1, bclk_s2, bclk_d;
  logic                  lrc_s1, lrc_s2;
  logic                  bclk_fall;
  phase_t                state, state_nxt;
  logic                  load_left, load_right;
  frame_t                mem [FIFO_DEPTH];
  frame_t                rd_dat;
  logic [AW:0]           wptr, rptr;
  logic                  fifo_empty, push_vld, pop_vld, run_q;
  logic [DATA_WIDTH-1:0] shreg, held_right;
  logic [CW-1:0]         bit_cnt;

  // Codec clocks are asynchronous; only the second-stage copies are used by the logic.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_d  <= 1'b0;
      lrc_s1  <= 1'b0;
      lrc_s2  <= 1'b0;
    end else begin
      bclk_s1 <= aud_bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lrc_s1  <= aud_daclrc;
      lrc_s2  <= lrc_s1;
    end
  end

  assign bclk_fall = bclk_d & ~bclk_s2;

  // Frame FIFO: pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifo_level = wptr - rptr;
  assign fifo_empty = (fifo_level == '0);
  assign s_ready    = run_q && (fifo_level < DEPTH_L);
  assign push_vld   = s_valid && s_ready;
  assign pop_vld    = load_left && !fifo_empty;
  assign rd_dat     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_clk) begin
    if (push_vld) begin
      mem[wptr[AW-1:0]] <= {s_left, s_right};
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (push_vld) wptr <= wptr + LW'(1);
      if (pop_vld)  rptr <= rptr + LW'(1);
    end
  end

  // The phase register doubles as the LRC value seen at the previous falling edge;
  // ST_INIT takes one sample first so a reset never fakes an LRC transition.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_left  = 1'b0;
    load_right = 1'b0;
    if (bclk_fall) begin
      case (state)
        ST_INIT:  state_nxt = lrc_s2 ? ST_RIGHT : ST_LEFT;
        ST_LEFT: begin
          if (lrc_s2) begin
            state_nxt  = ST_RIGHT;
            load_right = 1'b1;
          end
        end
        ST_RIGHT: begin
          if (!lrc_s2) begin
            state_nxt = ST_LEFT;
            load_left = 1'b1;
          end
        end
        default:  state_nxt = ST_INIT;
      endcase
    end
  end

  // Load edge drives 0; the MSB leaves on the following falling edge, giving the I2S delay.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      shreg      <= '0;
      held_right <= '0;
      bit_cnt    <= '0;
      aud_dacdat <= 1'b0;
    end else if (bclk_fall) begin
      if (load_left) begin
        shreg      <= pop_vld ? rd_dat.left  : '0;
        held_right <= pop_vld ? rd_dat.right : '0;
        bit_cnt    <= WORD_BITS;
        aud_dacdat <= 1'b0;
      end else if (load_right) begin
        shreg      <= held_right;
        bit_cnt    <= WORD_BITS;
        aud_dacdat <= 1'b0;
      end else if (bit_cnt != '0) begin
        aud_dacdat <= shreg[DATA_WIDTH-1];
        shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
        bit_cnt    <= bit_cnt - CW'(1);
      end else begin
        aud_dacdat <= 1'b0;
      end
    end
  end

  // A same-cycle underflow wins over the clear request.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      underflow <= 1'b0;
    end else if (load_left && fifo_empty) begin
      underflow <= 1'b1;
    end else if (clear_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Bench for audio_dac_i2s_tx: randomized frames and codec clocking against a queue-based
// model of the frame stream; serial bits are scoreboarded at each BCLK rising edge.
`timescale 1ns/1ps
module tb_audio_dac_i2s_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          aud_bclk = 1'b1;
  logic          aud_daclrc = 1'b1;
  logic          aud_dacdat;
  logic [LW-1:0] fifo_level;
  logic          underflow;
  logic          clear_underflow = 1'b0;

  always #5 clk_clk = ~clk_clk;

  audio_dac_i2s_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .s_left          (s_left),
    .s_right         (s_right),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .aud_bclk        (aud_bclk),
    .aud_daclrc      (aud_daclrc),
    .aud_dacdat      (aud_dacdat),
    .fifo_level      (fifo_level),
    .underflow       (underflow),
    .clear_underflow (clear_underflow)
  );

  // A BCLK falling edge driven by the bench becomes visible to the DUT logic after the
  // two synchronizer stages, and its effect lands at the third clk edge.
  typedef struct {
    int cyc;
    bit lrc;
  } ev_t;

  ev_t             ev_q[$];
  bit              exp_q[$];
  logic [2*DW-1:0] frm_q[$];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  push_pct = 0;
  bit  bclk_started = 1'b0;
  int  lens[5] = '{12, 16, 17, 18, 24};

  bit              m_run = 1'b0, m_rst = 1'b1, m_uf = 1'b0;
  bit              m_have_ref = 1'b0, m_prev_lrc = 1'b0;
  logic [DW-1:0]   m_word = '0, m_held = '0;
  int              m_idx = DW + 1;
  bit              m_rdy, m_set_uf, m_bit;
  logic [2*DW-1:0] m_f;
  ev_t             m_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame queue plus "bits since the last LRC change".
  initial forever begin
    @(posedge clk_clk);
    cyc++;
    if (!reset_reset_n) begin
      frm_q.delete();
      ev_q.delete();
      m_uf = 1'b0; m_run = 1'b0; m_rst = 1'b1; m_have_ref = 1'b0;
      m_word = '0; m_held = '0; m_idx = DW + 1;
    end else begin
      m_rst    = 1'b0;
      m_rdy    = m_run && (frm_q.size() < DEPTH);
      m_set_uf = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        m_ev = ev_q.pop_front();
        if (m_have_ref && m_prev_lrc && !m_ev.lrc) begin
          if (frm_q.size() > 0) begin
            m_f    = frm_q.pop_front();
            m_word = m_f[2*DW-1:DW];
            m_held = m_f[DW-1:0];
          end else begin
            m_word   = '0;
            m_held   = '0;
            m_set_uf = 1'b1;
          end
          m_idx = 0;
        end else if (m_have_ref && !m_prev_lrc && m_ev.lrc) begin
          m_word = m_held;
          m_idx  = 0;
        end else if (m_idx <= DW) begin
          m_idx++;
        end
        m_have_ref = 1'b1;
        m_prev_lrc = m_ev.lrc;
        m_bit = (m_idx >= 1 && m_idx <= DW) ? m_word[DW-m_idx] : 1'b0;
        exp_q.push_back(m_bit);
      end
      if (m_set_uf) m_uf = 1'b1;
      else if (clear_underflow) m_uf = 1'b0;
      if (s_valid && m_rdy) frm_q.push_back({s_left, s_right});
      m_run = 1'b1;
    end
  end

  // Serial data monitor: one expected bit per BCLK falling edge, sampled at the rise.
  initial forever begin
    @(posedge aud_bclk);
    if (bclk_started) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dacdat_sb: got %0b with no expected bit queued (cycle %0d)", aud_dacdat, cyc);
      end else begin
        check("dacdat", aud_dacdat, exp_q.pop_front());
      end
    end
  end

  // Status monitor, sampled on the inactive clock edge.
  initial forever begin
    @(negedge clk_clk);
    if (cyc > 0) begin
      check("fifo_level", fifo_level, frm_q.size());
      check("s_ready", s_ready, m_run && (frm_q.size() < DEPTH));
      check("underflow", underflow, m_uf);
      if (m_rst) check("dacdat_in_reset", aud_dacdat, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_inputs(input bit force_push);
    logic [31:0] r;
    r = $urandom;
    s_valid = force_push || ($urandom_range(0, 99) < push_pct);
    s_left  = r[DW-1:0];
    s_right = r[31:32-DW];
    clear_underflow = 1'b0;
  endtask

  task automatic bclk_period(input bit lrc_v, input int push_k);
    ev_t e;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_clk);
      if (k == 0) begin
        aud_bclk   = 1'b0;
        aud_daclrc = lrc_v;
        e.cyc = cyc + 3;
        e.lrc = lrc_v;
        ev_q.push_back(e);
        bclk_started = 1'b1;
      end
      if (k == 4) aud_bclk = 1'b1;
      drive_inputs(k == push_k);
    end
  endtask

  // push_k = 2 places a push in the same clk cycle as the load triggered by the first edge.
  task automatic half(input bit lrc_v, input int n, input int push_k);
    for (int i = 0; i < n; i++) bclk_period(lrc_v, (i == 0) ? push_k : -1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_clk);
      s_valid = 1'b0;
      clear_underflow = 1'b0;
    end
  endtask

  task automatic push_now(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(negedge clk_clk);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    clear_underflow = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk_clk);
    s_valid = 1'b0;
    clear_underflow = 1'b1;
    @(negedge clk_clk);
    clear_underflow = 1'b0;
  endtask

  initial begin
    int n;
    repeat (4) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    idle(3);
    half(1'b1, 4, -1);

    // Known frame with room for the whole word, then zeros.
    push_now(16'hA5C3, 16'h0F01);
    idle(2);
    half(1'b0, 20, -1); half(1'b1, 20, -1);

    // Empty FIFO at the left load: silent frame, sticky underflow, then cleared.
    half(1'b0, 20, -1); half(1'b1, 20, -1);
    idle(4); pulse_clear(); idle(4);

    // Five back-to-back pushes with the codec idle: only four fit.
    for (int i = 0; i < 5; i++) push_now(DW'(16'h1000 + i), DW'(16'h2000 + i));
    idle(4);
    half(1'b0, 16, -1); half(1'b1, 16, -1);
    half(1'b0, 16, -1); half(1'b1, 16, -1);
    half(1'b0, 16, 2);  half(1'b1, 16, -1);
    half(1'b0, 16, -1); half(1'b1, 16, -1);
    half(1'b0, 16, -1); half(1'b1, 16, -1);
    half(1'b0, 16, 2);  half(1'b1, 16, -1);
    pulse_clear();

    // Short half-frames truncate each word.
    push_pct = 3;
    repeat (4) begin half(1'b0, 12, -1); half(1'b1, 12, -1); end

    // Reset in the middle of a left word, then resume the codec stream.
    half(1'b0, 6, -1);
    push_pct = 0;
    idle(2);
    reset_reset_n = 1'b0;
    idle(3);
    reset_reset_n = 1'b1;
    idle(3);
    push_pct = 4;
    half(1'b0, 6, -1); half(1'b1, 12, -1);
    half(1'b0, 12, -1); half(1'b1, 12, -1);

    repeat (16) begin
      n = lens[$urandom_range(0, 4)];
      push_pct = $urandom_range(1, 6);
      half(1'b0, n, -1);
      half(1'b1, n, -1);
    end

    push_pct = 0;
    idle(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
